// File: rtl/riscv_core_dpath_load_queue_pkg.sv
// Shared definitions for the data-memory load response queue.
// Holds the load function encodings used by the queue and the subword adjuster.
package riscv_core_dpath_load_queue_pkg;

    localparam int unsigned FN_W   = 3;
    localparam int unsigned DATA_W = 32;

    localparam logic [FN_W-1:0] LD_W  = 3'd0;
    localparam logic [FN_W-1:0] LD_B  = 3'd1;
    localparam logic [FN_W-1:0] LD_BU = 3'd2;
    localparam logic [FN_W-1:0] LD_H  = 3'd3;
    localparam logic [FN_W-1:0] LD_HU = 3'd4;

endpackage

// File: rtl/riscv_core_dpath_subword_adj.sv
// Combinational subword extraction and sign/zero extension of a raw dmem word.
// Reserved fn codes pass the raw word through; halfword offset bit 0 is ignored.
module riscv_core_dpath_subword_adj
    import riscv_core_dpath_load_queue_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [FN_W-1:0]   fn,
    input  logic [1:0]        off,
    output logic [DATA_W-1:0] adj_c
);

    logic [DATA_W-1:0] lane;
    logic [15:0]       half;

    assign lane = data >> {off, 3'b000};
    assign half = off[1] ? data[31:16] : data[15:0];

    always_comb begin
        adj_c = data;
        case (fn)
            LD_B:    adj_c = {{24{lane[7]}}, lane[7:0]};
            LD_BU:   adj_c = {24'd0, lane[7:0]};
            LD_H:    adj_c = {{16{half[15]}}, half};
            LD_HU:   adj_c = {16'd0, half};
            default: adj_c = data;
        endcase
    end

endmodule

// File: rtl/riscv_core_dpath_load_queue.sv
// N-entry dmem response queue with subword adjustment on enqueue and squash flush.
// Define RISCV_LDQ_BYPASS_EN for combinational flow-through when the queue is empty.
module riscv_core_dpath_load_queue
    import riscv_core_dpath_load_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_val,
    output logic                       enq_rdy,
    input  logic [31:0]                enq_data,
    input  logic [2:0]                 enq_fn,
    input  logic [1:0]                 enq_off,
    input  logic [TAG_W-1:0]           enq_tag,
    output logic                       deq_val,
    input  logic                       deq_rdy,
    output logic [31:0]                deq_data,
    output logic [TAG_W-1:0]           deq_tag,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0]  mem_tag  [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [DATA_W-1:0] adj_data;
    logic              empty;
    logic              enq_fire;
    logic              wr_en;
    logic              rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    riscv_core_dpath_subword_adj u_adj (
        .data  (enq_data),
        .fn    (enq_fn),
        .off   (enq_off),
        .adj_c (adj_data)
    );

    assign empty    = (count == '0);
    assign enq_rdy  = (count != CNT_W'(DEPTH)) && !flush;
    assign enq_fire = enq_val && enq_rdy;

`ifdef RISCV_LDQ_BYPASS_EN
    // Empty queue forwards the adjusted input; a same-cycle accept skips storage.
    assign deq_val  = !flush && (!empty || enq_val);
    assign deq_data = empty ? adj_data : mem_data[head];
    assign deq_tag  = empty ? enq_tag  : mem_tag[head];
    assign rd_en    = deq_val && deq_rdy && !empty;
    assign wr_en    = enq_fire && !(empty && deq_rdy);
`else
    assign deq_val  = !flush && !empty;
    assign deq_data = mem_data[head];
    assign deq_tag  = mem_tag[head];
    assign rd_en    = deq_val && deq_rdy;
    assign wr_en    = enq_fire;
`endif

    // Entry storage carries no reset; contents are qualified by count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[tail] <= adj_data;
            mem_tag[tail]  <= enq_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) tail <= ptr_inc(tail);
            if (rd_en) head <= ptr_inc(head);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
